target_generator: RTL

Generates the apple (target) cell address consumed by the snake controller as Random_Target_Address, using the {X[7:0], Y[6:0]} packing on the 160x120 cell grid. A free-running 16-bit LFSR proposes candidate cells. A draw/check state machine rejects any candidate that is off the playfield, on the snake head, on a lit obstacle, or equal to the previous target. A new target is drawn on entry to PLAY and after every Reached_Target pulse.

---
 rtl/snake_pkg.sv | 46 ++++
 rtl/snake_lfsr16.sv | 33 +++
 rtl/target_generator.sv | 134 +++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared playfield geometry, game-state codes and {X,Y} cell packing
// for the snake game blocks.
package snake_pkg;

   // {X,Y} cell address packing
   localparam int X_W    = 8;
   localparam int Y_W    = 7;
   localparam int ADDR_W = X_W + Y_W;

   // Master state machine codes driven on MSM_State
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      PLAY = 2'b01,
      WIN  = 2'b10,
      FAIL = 2'b11
   } msm_state_t;

   // Target generator internal states
   typedef enum logic [1:0] {
      T_IDLE,
      T_DRAW,
      T_CHECK,
      T_HOLD
   } tgen_state_t;

   // Playfield is 160x120 cells; the outermost ring is wall
   localparam int GRID_W    = 160;
   localparam int GRID_H    = 120;
   localparam int WALL_X_LO = 0;
   localparam int WALL_X_HI = GRID_W - 1;
   localparam int WALL_Y_LO = 0;
   localparam int WALL_Y_HI = GRID_H - 1;

   function automatic logic [ADDR_W-1:0] pack_xy(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
      return {x, y};
   endfunction

   // Obstacle cells, index 0 is block1
   localparam logic [3:0][ADDR_W-1:0] BLOCK_ADDR = {
      pack_xy(8'd60, 7'd60),
      pack_xy(8'd55, 7'd33),
      pack_xy(8'd40, 7'd15),
      pack_xy(8'd28, 7'd11)
   };

endpackage

// File: rtl/snake_lfsr16.sv
// Free-running 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1.
// A non-zero seed keeps it off the all-zero lock-up state forever.
module snake_lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        CLK,
   input  logic        RESET,
   output logic [15:0] q
);

   localparam logic [15:0] TAP_MASK = 16'hB400;

   logic [15:0] lfsr_reg;
   logic [15:0] lfsr_next;

   // Shift right, folding the tap mask in when a one falls out of bit 0
   always_comb begin
      lfsr_next = lfsr_reg >> 1;
      if (lfsr_reg[0])
         lfsr_next = (lfsr_reg >> 1) ^ TAP_MASK;
   end

   // State register, steps every cycle
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)
         lfsr_reg <= SEED;
      else
         lfsr_reg <= lfsr_next;
   end

   assign q = lfsr_reg;

endmodule

// File: rtl/target_generator.sv
// Apple (target) cell generator. Draws LFSR candidates, rejects illegal
// cells, and falls back to a fixed cell after too many rejects.
module target_generator
   import snake_pkg::*;
#(
   parameter logic [15:0]       LFSR_SEED  = 16'hACE1,
   parameter logic [X_W-1:0]    X_MIN      = X_W'(WALL_X_LO + 1),
   parameter logic [X_W-1:0]    X_MAX      = X_W'(WALL_X_HI - 1),
   parameter logic [Y_W-1:0]    Y_MIN      = Y_W'(WALL_Y_LO + 1),
   parameter logic [Y_W-1:0]    Y_MAX      = Y_W'(WALL_Y_HI - 1),
   parameter logic [7:0]        MAX_RETRY  = 8'd63,
   parameter logic [ADDR_W-1:0] FALLBACK_A = {8'd40, 7'd60},
   parameter logic [ADDR_W-1:0] FALLBACK_B = {8'd120, 7'd60}
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [1:0]        MSM_State,
   input  logic              Reached_Target,
   input  logic [ADDR_W-1:0] Head_Address,
   input  logic [3:0]        Block_Light,
   output logic [ADDR_W-1:0] Random_Target_Address,
   output logic              Target_Valid,
   output logic [7:0]        Gen_Count,
   output logic              Fallback_Used
);

   logic [15:0]       lfsr_q;
   logic              unused_lfsr_msb;
   tgen_state_t       state_reg;
   logic [ADDR_W-1:0] cand_reg;
   logic [ADDR_W-1:0] prev_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [7:0]        retry_reg;
   logic [7:0]        gen_reg;
   logic              valid_reg;
   logic              fb_used_reg;

   logic [X_W-1:0]    cand_x;
   logic [Y_W-1:0]    cand_y;
   logic [3:0]        block_hit;
   logic              cand_reject;
   logic              take_fallback;
   logic [ADDR_W-1:0] fallback_addr;
   logic [ADDR_W-1:0] accept_addr;

   snake_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .CLK   (CLK),
      .RESET (RESET),
      .q     (lfsr_q)
   );

   // Bit 15 never reaches the candidate decode
   assign unused_lfsr_msb = lfsr_q[15];

   assign cand_x = cand_reg[ADDR_W-1:Y_W];
   assign cand_y = cand_reg[Y_W-1:0];

   // One comparator per obstacle; only lit obstacles block a cell
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_block
         assign block_hit[gi] = Block_Light[gi] && (cand_reg == BLOCK_ADDR[gi]);
      end
   endgenerate

   // Candidate legality and the fallback choice
   always_comb begin
      cand_reject   = (cand_x < X_MIN) || (cand_x > X_MAX) ||
                      (cand_y < Y_MIN) || (cand_y > Y_MAX) ||
                      (cand_reg == Head_Address) || (|block_hit) ||
                      (cand_reg == prev_reg);
      fallback_addr = (FALLBACK_A == Head_Address) ? FALLBACK_B : FALLBACK_A;
      take_fallback = cand_reject && (retry_reg == MAX_RETRY);
      accept_addr   = cand_reject ? fallback_addr : cand_reg;
   end

   // Draw/check/hold sequencer; leaving PLAY overrides everything
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_reg   <= T_IDLE;
         cand_reg    <= '0;
         prev_reg    <= '0;
         addr_reg    <= '0;
         retry_reg   <= '0;
         gen_reg     <= '0;
         valid_reg   <= 1'b0;
         fb_used_reg <= 1'b0;
      end else if (msm_state_t'(MSM_State) != PLAY) begin
         state_reg   <= T_IDLE;
         prev_reg    <= '0;
         addr_reg    <= '0;
         retry_reg   <= '0;
         gen_reg     <= '0;
         valid_reg   <= 1'b0;
         fb_used_reg <= 1'b0;
      end else begin
         case (state_reg)
            T_IDLE: state_reg <= T_DRAW;
            T_DRAW: begin
               cand_reg  <= {lfsr_q[7:0], lfsr_q[14:8]};
               state_reg <= T_CHECK;
            end
            T_CHECK: begin
               if (cand_reject && !take_fallback) begin
                  retry_reg <= retry_reg + 8'd1;
                  state_reg <= T_DRAW;
               end else begin
                  addr_reg  <= accept_addr;
                  prev_reg  <= accept_addr;
                  valid_reg <= 1'b1;
                  gen_reg   <= gen_reg + 8'd1;
                  retry_reg <= '0;
                  if (take_fallback)
                     fb_used_reg <= 1'b1;
                  state_reg <= T_HOLD;
               end
            end
            T_HOLD: begin
               if (Reached_Target) begin
                  valid_reg <= 1'b0;
                  addr_reg  <= '0;
                  state_reg <= T_DRAW;
               end
            end
            default: state_reg <= T_IDLE;
         endcase
      end
   end

   assign Random_Target_Address = addr_reg;
   assign Target_Valid          = valid_reg;
   assign Gen_Count             = gen_reg;
   assign Fallback_Used         = fb_used_reg;

endmodule
